// File: rtl/systolic_pe_ctrl.sv
// Job sequencer for one 4-bit systolic PE: loads weight/bias, streams K samples
// with accumulate enables, then captures the saturated accumulator as a result.
module systolic_pe_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       cfg_weight,
    input  logic [3:0]       cfg_bias,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_keep_weight,
    input  logic             abort,
    output logic             busy,
    input  logic [3:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [3:0]       pe_data,
    output logic [3:0]       pe_weight,
    output logic [3:0]       pe_bias,
    output logic             pe_weight_en,
    output logic             pe_bias_en,
    output logic             pe_acc_en,
    input  logic [7:0]       pe_acc,
    output logic [7:0]       result,
    output logic             result_sat,
    output logic             result_valid,
    input  logic             result_ready
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_MAC    = 3'd2,
        S_DRAIN1 = 3'd3,
        S_DRAIN2 = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ZERO = '0;
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic             busy_q, busy_d;
    logic             s_ready_q, s_ready_d;
    logic [3:0]       pe_data_q, pe_data_d;
    logic [3:0]       pe_weight_q, pe_weight_d;
    logic [3:0]       pe_bias_q, pe_bias_d;
    logic             pe_weight_en_q, pe_weight_en_d;
    logic             pe_bias_en_q, pe_bias_en_d;
    logic             pe_acc_en_q, pe_acc_en_d;
    logic [7:0]       result_q, result_d;
    logic             result_sat_q, result_sat_d;
    logic             result_valid_q, result_valid_d;
    logic             mac_hs_s;

    function automatic logic is_sat(input logic [7:0] v);
        return (v == 8'h7F) || (v == 8'h80);
    endfunction

    assign mac_hs_s = s_valid & s_ready_q;

    // Next-state and next-output logic; abort overrides everything outside IDLE
    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        pe_data_d      = pe_data_q;
        pe_weight_d    = pe_weight_q;
        pe_bias_d      = pe_bias_q;
        pe_weight_en_d = 1'b0;
        pe_bias_en_d   = 1'b0;
        pe_acc_en_d    = 1'b0;
        s_ready_d      = 1'b0;
        result_d       = result_q;
        result_sat_d   = result_sat_q;
        result_valid_d = 1'b0;

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d        = S_LOAD;
                        remaining_d    = cfg_len;
                        pe_weight_d    = cfg_weight;
                        pe_bias_d      = cfg_bias;
                        pe_weight_en_d = ~cfg_keep_weight;
                        pe_bias_en_d   = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (remaining_q != LEN_ZERO) begin
                        state_d   = S_MAC;
                        s_ready_d = 1'b1;
                    end else begin
                        state_d = S_DRAIN1;
                    end
                end
                S_MAC: begin
                    if (mac_hs_s) begin
                        pe_data_d   = s_data;
                        pe_acc_en_d = 1'b1;
                        remaining_d = remaining_q - LEN_ONE;
                        if (remaining_q == LEN_ONE) begin
                            state_d = S_DRAIN1;
                        end else begin
                            s_ready_d = 1'b1;
                        end
                    end else begin
                        s_ready_d = (remaining_q != LEN_ZERO);
                    end
                end
                S_DRAIN1: begin
                    state_d = S_DRAIN2;
                end
                S_DRAIN2: begin
                    // PE has finished the last MAC, so its output is final here
                    state_d        = S_DONE;
                    result_d       = pe_acc;
                    result_sat_d   = is_sat(pe_acc);
                    result_valid_d = 1'b1;
                end
                S_DONE: begin
                    if (result_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        result_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            remaining_q    <= LEN_ZERO;
            busy_q         <= 1'b0;
            s_ready_q      <= 1'b0;
            pe_data_q      <= 4'h0;
            pe_weight_q    <= 4'h0;
            pe_bias_q      <= 4'h0;
            pe_weight_en_q <= 1'b0;
            pe_bias_en_q   <= 1'b0;
            pe_acc_en_q    <= 1'b0;
            result_q       <= 8'h00;
            result_sat_q   <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            busy_q         <= busy_d;
            s_ready_q      <= s_ready_d;
            pe_data_q      <= pe_data_d;
            pe_weight_q    <= pe_weight_d;
            pe_bias_q      <= pe_bias_d;
            pe_weight_en_q <= pe_weight_en_d;
            pe_bias_en_q   <= pe_bias_en_d;
            pe_acc_en_q    <= pe_acc_en_d;
            result_q       <= result_d;
            result_sat_q   <= result_sat_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign busy         = busy_q;
    assign s_ready      = s_ready_q;
    assign pe_data      = pe_data_q;
    assign pe_weight    = pe_weight_q;
    assign pe_bias      = pe_bias_q;
    assign pe_weight_en = pe_weight_en_q;
    assign pe_bias_en   = pe_bias_en_q;
    assign pe_acc_en    = pe_acc_en_q;
    assign result       = result_q;
    assign result_sat   = result_sat_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_systolic_pe_ctrl.sv
// Scoreboard bench for systolic_pe_ctrl with a behavioural 4-bit PE attached.
module tb_systolic_pe_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, cfg_keep_weight, abort, s_valid, result_ready;
    logic [3:0] cfg_weight, cfg_bias, s_data;
    logic [7:0] cfg_len;
    logic       busy, s_ready, pe_weight_en, pe_bias_en, pe_acc_en;
    logic [3:0] pe_data, pe_weight, pe_bias;
    logic [7:0] pe_acc, result;
    logic       result_sat, result_valid;

    systolic_pe_ctrl #(.LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_weight(cfg_weight),
        .cfg_bias(cfg_bias), .cfg_len(cfg_len), .cfg_keep_weight(cfg_keep_weight),
        .abort(abort), .busy(busy), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .pe_data(pe_data), .pe_weight(pe_weight),
        .pe_bias(pe_bias), .pe_weight_en(pe_weight_en), .pe_bias_en(pe_bias_en),
        .pe_acc_en(pe_acc_en), .pe_acc(pe_acc), .result(result),
        .result_sat(result_sat), .result_valid(result_valid),
        .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    // Behavioural PE: bias load resets acc, MAC saturates to signed 8 bits
    logic signed [7:0] acc_m;
    logic signed [3:0] w_m;
    function automatic logic signed [7:0] sat_mac(input logic signed [7:0] a,
                                                  input logic signed [3:0] w,
                                                  input logic signed [3:0] d);
        int s;
        s = int'(a) + int'(w) * int'(d);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return 8'(s);
    endfunction
    always @(posedge clk) begin
        if (rst) begin
            acc_m <= 8'sd0;
            w_m   <= 4'sd0;
        end else begin
            if (pe_weight_en) w_m <= pe_weight;
            if (pe_bias_en) acc_m <= {{4{pe_bias[3]}}, pe_bias};
            else if (pe_acc_en) acc_m <= sat_mac(acc_m, w_m, pe_data);
        end
    end
    assign pe_acc = acc_m;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] res;
        logic       sat;
        int         lat;
    } exp_t;
    exp_t sb[$];
    exp_t e_m;

    int checks = 0, failures = 0;
    int start_cyc = 0;
    int acc_cnt = 0, we_cnt = 0, be_cnt = 0;
    logic rv_prev = 1'b0, hs_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [3:0] w, input logic [3:0] b, input logic [7:0] len,
                         input logic keep, input logic push, input logic [7:0] res,
                         input logic sat, input int lat);
        start = 1'b1; cfg_weight = w; cfg_bias = b; cfg_len = len; cfg_keep_weight = keep;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc - 1;
        if (push) sb.push_back('{res: res, sat: sat, lat: lat});
    endtask

    task automatic beat(input logic [3:0] d);
        logic ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (s_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        chk("beat_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && result_valid === 1'b0) done = 1'b1;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    function automatic logic [26:0] out_vec();
        return {busy, s_ready, pe_data, pe_weight, pe_bias, pe_weight_en, pe_bias_en,
                pe_acc_en, result, result_sat, result_valid};
    endfunction

    initial begin
        int a0, w0, b0;
        logic got_valid;
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 4'h0;
        cfg_weight = 4'h0; cfg_bias = 4'h0; cfg_len = 8'd0; cfg_keep_weight = 1'b0;
        result_ready = 1'b1;

        // Monitor: pops the scoreboard on each rising result_valid
        fork
            forever begin
                @(negedge clk);
                if (rst !== 1'b0) begin
                    rv_prev = 1'b0;
                    hs_prev = 1'b0;
                end else begin
                    chk("acc_en_after_hs", {31'd0, pe_acc_en}, {31'd0, hs_prev});
                    if (pe_acc_en) acc_cnt++;
                    if (pe_weight_en) we_cnt++;
                    if (pe_bias_en) be_cnt++;
                    if (result_valid === 1'b1 && !rv_prev) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_result_valid", 32'd1, 32'd0);
                        end else begin
                            e_m = sb.pop_front();
                            chk("result", {24'd0, result}, {24'd0, e_m.res});
                            chk("result_sat", {31'd0, result_sat}, {31'd0, e_m.sat});
                            chk("result_latency", cyc - start_cyc, e_m.lat);
                        end
                    end
                    rv_prev = (result_valid === 1'b1);
                    hs_prev = (s_valid === 1'b1) && (s_ready === 1'b1);
                end
            end
        join_none

        tick(3);
        chk("reset_outputs", {5'd0, out_vec()}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Job 1: w=3 b=-2 K=3, samples 1,2,3, result held with ready low
        a0 = acc_cnt;
        result_ready = 1'b0;
        issue(4'd3, 4'hE, 8'd3, 1'b0, 1'b1, 8'd16, 1'b0, 7);
        beat(4'd1); beat(4'd2); beat(4'd3);
        got_valid = 1'b0;
        for (int i = 0; i < 50 && !got_valid; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) got_valid = 1'b1;
        end
        tick(3);
        chk("valid_held", {31'd0, result_valid}, 32'd1);
        chk("result_held", {24'd0, result}, 32'd16);
        result_ready = 1'b1;
        wait_idle("job1_idle");
        chk("job1_acc_pulses", acc_cnt - a0, 3);

        // Job 2: same job, two-cycle stall before sample 3
        a0 = acc_cnt;
        issue(4'd3, 4'hE, 8'd3, 1'b0, 1'b1, 8'd16, 1'b0, 9);
        beat(4'd1); beat(4'd2);
        tick(2);
        beat(4'd3);
        wait_idle("job2_idle");
        chk("job2_acc_pulses", acc_cnt - a0, 3);

        // Job 3: saturating job
        issue(4'd7, 4'd7, 8'd3, 1'b0, 1'b1, 8'h7F, 1'b1, 7);
        beat(4'd7); beat(4'd7); beat(4'd7);
        wait_idle("job3_idle");

        // Job 4: K=0, result is sign-extended bias
        w0 = we_cnt; b0 = be_cnt;
        issue(4'd7, 4'hD, 8'd0, 1'b0, 1'b1, 8'hFD, 1'b0, 4);
        wait_idle("job4_idle");
        chk("job4_weight_en", we_cnt - w0, 1);
        chk("job4_bias_en", be_cnt - b0, 1);

        // Job 5: reuse weight 7 even though cfg_weight differs
        w0 = we_cnt; b0 = be_cnt;
        issue(4'd1, 4'd0, 8'd1, 1'b1, 1'b1, 8'd14, 1'b0, 5);
        beat(4'd2);
        wait_idle("job5_idle");
        chk("job5_weight_en", we_cnt - w0, 0);
        chk("job5_bias_en", be_cnt - b0, 1);

        // Abort after one of three samples
        issue(4'd3, 4'd1, 8'd3, 1'b0, 1'b0, 8'd0, 1'b0, 0);
        beat(4'd1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_s_ready", {31'd0, s_ready}, 32'd0);
        chk("abort_enables", {29'd0, pe_weight_en, pe_bias_en, pe_acc_en}, 32'd0);
        chk("abort_valid", {31'd0, result_valid}, 32'd0);
        tick(8);
        chk("abort_result_kept", {24'd0, result}, 32'd14);
        chk("abort_stays_idle", {31'd0, busy}, 32'd0);

        // Job after abort: w=2 b=-1, samples 5,-3 -> 3
        a0 = acc_cnt;
        issue(4'd2, 4'hF, 8'd2, 1'b0, 1'b1, 8'd3, 1'b0, 6);
        beat(4'd5); beat(4'hD);
        wait_idle("job6_idle");
        chk("job6_acc_pulses", acc_cnt - a0, 2);

        // Reset during DRAIN1 with a start while busy
        issue(4'd1, 4'd0, 8'd1, 1'b0, 1'b0, 8'd0, 1'b0, 0);
        start = 1'b1; cfg_len = 8'd1;
        tick(1);
        start = 1'b0;
        beat(4'd4);
        rst = 1'b1;
        tick(1);
        chk("rst_outputs", {5'd0, out_vec()}, 32'd0);
        rst = 1'b0;
        tick(10);
        chk("busy_start_not_queued", {31'd0, busy}, 32'd0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
